// File: rtl/nand_cycle_sequencer.sv
// nand_cycle_sequencer
//   Turns one NAND request (command byte, 0..5 address bytes and an optional
//   confirm byte) into a series of IO unit cycles. Each byte gets a one-cycle
//   io_activate pulse followed by a wait phase that completes once the IO unit
//   has been seen busy and then idle again.
//
// Ports
//   clk, reset      : clock, asynchronous active-high reset
//   start           : request strobe, sampled only in IDLE
//   cmd, cmd2       : command byte and confirm byte (cmd2 only with the macro)
//   addr, addr_cnt  : address bytes (byte 0 first) and count (6/7 act as 5)
//   io_activate     : one-cycle pulse starting an IO unit cycle
//   io_data         : byte to the IO unit, zero-extended to 16 bits
//   io_busy         : IO unit busy flag
//   cle, ale, nce   : NAND command latch, address latch, chip enable (low)
//   busy, done      : request in progress, one-cycle completion pulse
//
// Configuration
//   NAND_SEQ_CMD2_EN : adds the cmd2 port and the CMD2/CMD2_W confirm phase
//                      issued after the address bytes.
module nand_cycle_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  cmd,
`ifdef NAND_SEQ_CMD2_EN
  input  logic [7:0]  cmd2,
`endif
  input  logic [39:0] addr,
  input  logic [2:0]  addr_cnt,
  output logic        io_activate,
  output logic [15:0] io_data,
  input  logic        io_busy,
  output logic        cle,
  output logic        ale,
  output logic        nce,
  output logic        busy,
  output logic        done
);

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned ADDR_BITS = 40;
  localparam int unsigned CNT_W     = 3;
  localparam int unsigned IO_W      = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    CMD_W  = 3'd2,
    ADDR   = 3'd3,
    ADDR_W = 3'd4,
    CMD2   = 3'd5,
    CMD2_W = 3'd6,
    DONE   = 3'd7
  } state_t;

  // Where the sequence goes once the address phase (or its absence) is over.
`ifdef NAND_SEQ_CMD2_EN
  localparam state_t POST_ADDR = CMD2;
`else
  localparam state_t POST_ADDR = DONE;
`endif

  state_t               state_q;
  state_t               state_d;
  logic [BYTE_W-1:0]    cmd_q;
`ifdef NAND_SEQ_CMD2_EN
  logic [BYTE_W-1:0]    cmd2_q;
`endif
  logic [ADDR_BITS-1:0] addr_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     idx_q;
  logic                 seen_q;
  logic [CNT_W-1:0]     cnt_clamp_c;
  logic                 issue_c;
  logic                 wait_c;
  logic                 w_exit_c;
  logic                 more_addr_c;
  logic [BYTE_W-1:0]    addr_byte_c;

  assign cnt_clamp_c = (addr_cnt > CNT_W'(5)) ? CNT_W'(5) : addr_cnt;
  assign issue_c     = (state_q == CMD) || (state_q == ADDR) || (state_q == CMD2);
  assign wait_c      = (state_q == CMD_W) || (state_q == ADDR_W) || (state_q == CMD2_W);
  // A wait phase ends only after the IO unit went busy and then dropped busy.
  assign w_exit_c    = seen_q && !io_busy;
  assign more_addr_c = (idx_q + CNT_W'(1)) < cnt_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CMD;
      CMD:     state_d = CMD_W;
      CMD_W:   if (w_exit_c) state_d = (cnt_q != '0) ? ADDR : POST_ADDR;
      ADDR:    state_d = ADDR_W;
      ADDR_W:  if (w_exit_c) state_d = more_addr_c ? ADDR : POST_ADDR;
`ifdef NAND_SEQ_CMD2_EN
      CMD2:    state_d = CMD2_W;
      CMD2_W:  if (w_exit_c) state_d = DONE;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture, busy-seen flag and address byte index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q  <= '0;
`ifdef NAND_SEQ_CMD2_EN
      cmd2_q <= '0;
`endif
      addr_q <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      if ((state_q == IDLE) && start) begin
        cmd_q  <= cmd;
`ifdef NAND_SEQ_CMD2_EN
        cmd2_q <= cmd2;
`endif
        addr_q <= addr;
        cnt_q  <= cnt_clamp_c;
        idx_q  <= '0;
      end
      // Every issue state is followed by a wait state, so clearing here
      // gives each wait phase a fresh flag.
      if (issue_c) begin
        seen_q <= 1'b0;
      end else if (wait_c && io_busy) begin
        seen_q <= 1'b1;
      end
      if ((state_q == ADDR_W) && w_exit_c) begin
        idx_q <= idx_q + CNT_W'(1);
      end
    end
  end

  // Address byte selected by the current index.
  always_comb begin
    addr_byte_c = '0;
    case (idx_q)
      3'd0:    addr_byte_c = addr_q[7:0];
      3'd1:    addr_byte_c = addr_q[15:8];
      3'd2:    addr_byte_c = addr_q[23:16];
      3'd3:    addr_byte_c = addr_q[31:24];
      3'd4:    addr_byte_c = addr_q[39:32];
      default: addr_byte_c = '0;
    endcase
  end

  // Moore outputs decoded from the registered state and captured request.
  always_comb begin
    io_activate = 1'b0;
    io_data     = '0;
    cle         = 1'b0;
    ale         = 1'b0;
    nce         = 1'b1;
    busy        = 1'b1;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
      end
      CMD, CMD_W: begin
        io_activate = (state_q == CMD);
        io_data     = IO_W'(cmd_q);
        cle         = 1'b1;
        nce         = 1'b0;
      end
      ADDR, ADDR_W: begin
        io_activate = (state_q == ADDR);
        io_data     = IO_W'(addr_byte_c);
        ale         = 1'b1;
        nce         = 1'b0;
      end
`ifdef NAND_SEQ_CMD2_EN
      CMD2, CMD2_W: begin
        io_activate = (state_q == CMD2);
        io_data     = IO_W'(cmd2_q);
        cle         = 1'b1;
        nce         = 1'b0;
      end
`endif
      DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_nand_cycle_sequencer.sv
// tb_nand_cycle_sequencer
//   Scoreboard bench: every request pushes its expected IO cycles and pulse
//   count; a negedge monitor pops them as the sequencer issues cycles and
//   also plays the IO unit (busy for a few cycles after each activate).
module tb_nand_cycle_sequencer;

  localparam int unsigned WAIT_BUDGET = 400;
`ifdef NAND_SEQ_CMD2_EN
  localparam bit CMD2_ON = 1'b1;
`else
  localparam bit CMD2_ON = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] data;
    logic        cle;
    logic        ale;
  } issue_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  cmd = '0;
  logic [7:0]  cmd2 = '0;
  logic [39:0] addr = '0;
  logic [2:0]  addr_cnt = '0;
  logic        io_activate;
  logic [15:0] io_data;
  logic        io_busy = 1'b0;
  logic        cle;
  logic        ale;
  logic        nce;
  logic        busy;
  logic        done;

  issue_t issue_q[$];
  int     done_q[$];
  int     n_checks = 0;
  int     n_pass = 0;
  int     cyc = 0;
  int     last_fall = -10;
  int     rem = 0;
  int     pulse_cnt = 0;
  int     done_seen = 0;
  int     fixed_busy = 0;
  issue_t last_rec = '0;
  logic   last_v = 1'b0;

  nand_cycle_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .cmd         (cmd),
`ifdef NAND_SEQ_CMD2_EN
    .cmd2        (cmd2),
`endif
    .addr        (addr),
    .addr_cnt    (addr_cnt),
    .io_activate (io_activate),
    .io_data     (io_data),
    .io_busy     (io_busy),
    .cle         (cle),
    .ale         (ale),
    .nce         (nce),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic push_req(input logic [7:0] c, input logic [7:0] c2,
                          input logic [39:0] a, input logic [2:0] n_raw);
    issue_t r;
    int n;
    n = (n_raw > 3'd5) ? 5 : int'(n_raw);
    r.data = 16'(c); r.cle = 1'b1; r.ale = 1'b0;
    issue_q.push_back(r);
    for (int i = 0; i < n; i++) begin
      r.data = 16'(a[i*8 +: 8]); r.cle = 1'b0; r.ale = 1'b1;
      issue_q.push_back(r);
    end
    if (CMD2_ON) begin
      r.data = 16'(c2); r.cle = 1'b1; r.ale = 1'b0;
      issue_q.push_back(r);
    end
    done_q.push_back(1 + n + (CMD2_ON ? 1 : 0));
  endtask

  task automatic set_inputs(input logic [7:0] c, input logic [7:0] c2,
                            input logic [39:0] a, input logic [2:0] n);
    cmd = c; cmd2 = c2; addr = a; addr_cnt = n;
  endtask

  task automatic scramble();
    cmd = 8'($urandom); cmd2 = 8'($urandom);
    addr = {8'($urandom), 32'($urandom)}; addr_cnt = 3'($urandom);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (busy !== 1'b0 && k < WAIT_BUDGET) begin
      @(negedge clk);
      k++;
    end
    if (busy !== 1'b0) chk("idle_timeout", 64'(busy), 64'(0));
  endtask

  // Called at a negedge with the sequencer idle; start is accepted on the next edge.
  task automatic issue_req(input logic [7:0] c, input logic [7:0] c2,
                           input logic [39:0] a, input logic [2:0] n, output int d0);
    d0 = done_seen;
    set_inputs(c, c2, a, n);
    push_req(c, c2, a, n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble();
    chk("accept_busy", 64'(busy), 64'(1));
  endtask

  task automatic wait_done(input int d0);
    int k;
    k = 0;
    while (done_seen == d0 && k < WAIT_BUDGET) begin
      @(negedge clk);
      k++;
    end
    chk("done_timeout", 64'(done_seen != d0), 64'(1));
  endtask

  // Monitor / scoreboard plus IO unit model.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      rem = 0; io_busy = 1'b0; pulse_cnt = 0; last_v = 1'b0;
    end else begin
      if (io_activate) begin
        pulse_cnt++;
        chk("pulse_expected", 64'(issue_q.size() != 0), 64'(1));
        if (issue_q.size() != 0) begin
          last_rec = issue_q.pop_front();
          last_v = 1'b1;
          chk("pulse_data", 64'(io_data), 64'(last_rec.data));
          chk("pulse_cle", 64'(cle), 64'(last_rec.cle));
          chk("pulse_ale", 64'(ale), 64'(last_rec.ale));
          chk("pulse_nce", 64'(nce), 64'(0));
        end
      end else if (busy && !done && last_v) begin
        chk("hold_data", 64'(io_data), 64'(last_rec.data));
        chk("hold_cle", 64'(cle), 64'(last_rec.cle));
        chk("hold_ale", 64'(ale), 64'(last_rec.ale));
        chk("hold_nce", 64'(nce), 64'(0));
      end
      if (done) begin
        done_seen++;
        chk("done_expected", 64'(done_q.size() != 0), 64'(1));
        if (done_q.size() != 0) chk("pulse_count", 64'(pulse_cnt), 64'(done_q.pop_front()));
        chk("done_latency", 64'(cyc - last_fall), 64'(1));
        chk("done_nce", 64'(nce), 64'(1));
        chk("done_cle_ale", 64'({cle, ale}), 64'(0));
        pulse_cnt = 0;
        last_v = 1'b0;
      end
      if (io_activate) rem = (fixed_busy != 0) ? fixed_busy : int'($urandom_range(2, 4));
      if (rem > 0) begin
        io_busy = 1'b1;
        rem--;
      end else begin
        if (io_busy) last_fall = cyc;
        io_busy = 1'b0;
      end
    end
  end

  initial begin
    int d;
    int k;
    logic found;

    // Reset values while reset is held, before any clock edge.
    #3;
    chk("rst_act", 64'(io_activate), 64'(0));
    chk("rst_data", 64'(io_data), 64'(0));
    chk("rst_cle", 64'(cle), 64'(0));
    chk("rst_ale", 64'(ale), 64'(0));
    chk("rst_nce", 64'(nce), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    repeat (2) @(negedge clk);

    // Status read: start on the first edge after release, IO busy 3 cycles.
    reset = 1'b0;
    fixed_busy = 3;
    issue_req(8'h70, 8'h00, 40'h0, 3'd0, d);
    wait_done(d);

    // Full five-byte address with confirm byte, then clamped count.
    fixed_busy = 0;
    wait_idle();
    issue_req(8'h00, 8'h30, 40'h05_0403_0201, 3'd5, d);
    wait_done(d);
    wait_idle();
    issue_req(8'h60, 8'hD0, 40'h05_0403_0201, 3'd7, d);
    wait_done(d);

    // Random requests, counts 0..7.
    for (int t = 0; t < 8; t++) begin
      wait_idle();
      issue_req(8'($urandom), 8'($urandom), {8'($urandom), 32'($urandom)}, 3'($urandom), d);
      wait_done(d);
    end

    // Reset during the wait phase of address byte 3.
    wait_idle();
    issue_req(8'h80, 8'h10, 40'h05_0403_0201, 3'd5, d);
    found = 1'b0;
    k = 0;
    while (!found && k < WAIT_BUDGET) begin
      @(negedge clk);
      if (io_activate && ale && io_data == 16'h0003) found = 1'b1;
      k++;
    end
    chk("reach_byte3", 64'(found), 64'(1));
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_act", 64'(io_activate), 64'(0));
    chk("rst_mid_data", 64'(io_data), 64'(0));
    chk("rst_mid_cle", 64'(cle), 64'(0));
    chk("rst_mid_ale", 64'(ale), 64'(0));
    chk("rst_mid_nce", 64'(nce), 64'(1));
    chk("rst_mid_busy", 64'(busy), 64'(0));
    chk("rst_mid_done", 64'(done), 64'(0));
    issue_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    issue_req(8'h90, 8'h11, 40'h00_0000_BBAA, 3'd2, d);
    wait_done(d);

    // Start held high: back-to-back requests with an IDLE cycle between.
    wait_idle();
    set_inputs(8'hA1, 8'hB1, 40'h11_2233_4455, 3'd2);
    push_req(8'hA1, 8'hB1, 40'h11_2233_4455, 3'd2);
    start = 1'b1;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      chk("held_accept", 64'(busy), 64'(1));
      scramble();
      k = 0;
      while (!done && k < WAIT_BUDGET) begin
        @(negedge clk);
        k++;
      end
      chk("held_done", 64'(done), 64'(1));
      if (r < 2) begin
        set_inputs(8'(8'hC0 + r), 8'hE0, 40'h00_0000_7766, 3'(r + 1));
        push_req(8'(8'hC0 + r), 8'hE0, 40'h00_0000_7766, 3'(r + 1));
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      chk("held_idle_gap", 64'(busy), 64'(0));
    end

    repeat (6) @(negedge clk);
    chk("leftover_issue", 64'(issue_q.size()), 64'(0));
    chk("leftover_done", 64'(done_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
